// File: rtl/tp_strobe_stretch_if.sv
// Strobe-stretcher bus: fabric strobes and controls in, test-point pulses and event readback out.
interface tp_strobe_stretch_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = 8,
    parameter int unsigned ECW = 16
);
    localparam int unsigned CSW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] STB_IN;
    logic [SW-1:0]  STRETCH;
    logic [CSW-1:0] CNT_SEL;
    logic           CNT_CLR;
    logic [NCH-1:0] TP_OUT;
    logic [ECW-1:0] CNT_OUT;
    logic [NCH-1:0] MERGED;

    modport master (
        output STB_IN, STRETCH, CNT_SEL, CNT_CLR,
        input  TP_OUT, CNT_OUT, MERGED
    );

    modport slave (
        input  STB_IN, STRETCH, CNT_SEL, CNT_CLR,
        output TP_OUT, CNT_OUT, MERGED
    );
endinterface

// File: rtl/tp_strobe_stretch.sv
// Stretches single-cycle fabric strobes into scope-visible test-point pulses and
// keeps a saturating per-channel event count so merged strobes remain accounted for.
module tp_strobe_stretch #(
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = 8,
    parameter int unsigned ECW = 16,
    parameter int unsigned GAP = 2
) (
    input logic                CLK,
    input logic                RST_B,
    tp_strobe_stretch_if.slave bus
);
    localparam int unsigned    GW      = $clog2(GAP + 1);
    localparam logic [SW-1:0]  ONE_SW  = SW'(1);
    localparam logic [GW-1:0]  ONE_GW  = GW'(1);
    localparam logic [GW-1:0]  GAP_LD  = GW'(GAP);
    localparam logic [ECW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, HOLD, LOW_GAP} state_e;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [SW-1:0]  hold_q  [NCH];
    logic [SW-1:0]  hold_d  [NCH];
    logic [GW-1:0]  gap_q   [NCH];
    logic [GW-1:0]  gap_d   [NCH];
    logic [ECW-1:0] cnt_q   [NCH];
    logic [ECW-1:0] cnt_d   [NCH];

    logic [NCH-1:0] in_q, in_d;
    logic [NCH-1:0] tp_q, tp_d;
    logic [NCH-1:0] inc_q, inc_d;
    logic [NCH-1:0] mrg_ev_q, mrg_ev_d;
    logic [NCH-1:0] merged_q, merged_d;
    logic [ECW-1:0] cnt_out_q, cnt_out_d;
    logic [NCH-1:0] edge_c, start_c;
    logic [SW-1:0]  len_c;

    assign in_d   = bus.STB_IN;
    assign edge_c = bus.STB_IN & ~in_q;
    assign len_c  = (bus.STRETCH == '0) ? ONE_SW : bus.STRETCH;

    // Per-channel pulse FSM; the last gap cycle already accepts a new edge as if idle.
    always_comb begin
        start_c = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            gap_d[i]   = gap_q[i];
            unique case (state_q[i])
                IDLE: begin
                    start_c[i] = edge_c[i];
                end
                HOLD: begin
                    hold_d[i] = hold_q[i] - ONE_SW;
                    if (hold_q[i] == ONE_SW) begin
                        state_d[i] = LOW_GAP;
                        gap_d[i]   = GAP_LD;
                    end
                end
                LOW_GAP: begin
                    gap_d[i] = gap_q[i] - ONE_GW;
                    if (gap_q[i] == ONE_GW) begin
                        state_d[i] = IDLE;
                        start_c[i] = edge_c[i];
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (start_c[i]) begin
                state_d[i] = HOLD;
                hold_d[i]  = len_c;
            end
        end
    end

    // Event accounting lags the edge by one cycle; a clear on either cycle drops it.
    always_comb begin
        inc_d     = edge_c & {NCH{~bus.CNT_CLR}};
        mrg_ev_d  = edge_c & ~start_c & {NCH{~bus.CNT_CLR}};
        merged_d  = bus.CNT_CLR ? '0 : (merged_q | mrg_ev_q);
        tp_d      = '0;
        cnt_out_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.CNT_CLR) begin
                cnt_d[i] = '0;
            end else if (inc_q[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + ECW'(1);
            end
            tp_d[i] = (state_q[i] == HOLD);
        end
        if (32'(bus.CNT_SEL) < NCH) begin
            cnt_out_d = cnt_q[bus.CNT_SEL];
        end
    end

    // Input register keeps tracking through reset so a held level is never seen as an edge.
    always_ff @(posedge CLK) begin
        in_q <= in_d;
        if (!RST_B) begin
            tp_q      <= '0;
            inc_q     <= '0;
            mrg_ev_q  <= '0;
            merged_q  <= '0;
            cnt_out_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
                gap_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            tp_q      <= tp_d;
            inc_q     <= inc_d;
            mrg_ev_q  <= mrg_ev_d;
            merged_q  <= merged_d;
            cnt_out_q <= cnt_out_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                gap_q[i]   <= gap_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.TP_OUT  = tp_q;
    assign bus.CNT_OUT = cnt_out_q;
    assign bus.MERGED  = merged_q;

endmodule
